// File: rtl/md_unit_pkg.sv
// -----------------------------------------------------------------------------
// md_defs : shared definitions for the EX-stage multiply/divide unit.
//   MD_OP_W  - width of the MD opcode
//   md_op_e  - MD_* opcodes (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
//              MD_MTHI, MD_MTLO)
//   is_mul / is_div - opcode class helpers used by the unit and its arithmetic
// -----------------------------------------------------------------------------
package md_defs;

  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  function automatic logic is_mul(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// -----------------------------------------------------------------------------
// md_unit_if : EX-stage <-> multiply/divide unit connection.
//   start    - EX holds a valid MD op this cycle
//   op       - MD_* opcode (sampled only with start=1)
//   rs_data  - forwarded rs (multiplicand / dividend / MTHI, MTLO source)
//   rt_data  - forwarded rt (multiplier / divisor)
//   rd_sel   - 0 selects LO, 1 selects HI on rd_data
//   busy     - start | running, for same-cycle stall decisions
//   hi, lo   - architectural HI/LO
//   rd_data  - rd_sel ? hi : lo
// master = pipeline side, slave = md_unit.
// -----------------------------------------------------------------------------
interface md_unit_if;

  logic              start;
  md_defs::md_op_e   op;
  logic [31:0]       rs_data;
  logic [31:0]       rt_data;
  logic              rd_sel;
  logic              busy;
  logic [31:0]       hi;
  logic [31:0]       lo;
  logic [31:0]       rd_data;

  modport master (
    output start, op, rs_data, rt_data, rd_sel,
    input  busy, hi, lo, rd_data
  );

  modport slave (
    input  start, op, rs_data, rt_data, rd_sel,
    output busy, hi, lo, rd_data
  );

endinterface

// File: rtl/md_unit_arith.sv
// -----------------------------------------------------------------------------
// md_arith : combinational multiply/divide datapath.
//   op      in  MD_* opcode
//   a, b    in  32-bit operands (rs, rt)
//   res_hi  out product[63:32] or remainder
//   res_lo  out product[31:0]  or quotient
//   div0    out divide op with b == 0 (result must not be committed)
// -----------------------------------------------------------------------------
module md_arith
  import md_defs::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        b_zero;
  logic [31:0] b_safe;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;

  // The low 64 bits of a product of sign-extended operands equal the signed
  // product, so a plain unsigned multiplier serves both cases.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divisor forced to 1 on zero so the divider never sees x/0; the result
  // is discarded by the caller through div0.
  assign b_zero = (b == 32'd0);
  assign b_safe = b_zero ? 32'd1 : b;

  // Signed divide on magnitudes: quotient sign = a^b, remainder follows a.
  // |0x80000000| = 0x80000000 as unsigned, so the overflow case
  // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
  assign a_neg = a[31];
  assign b_neg = b_safe[31];
  assign a_mag = a_neg ? (~a + 32'd1) : a;
  assign b_mag = b_neg ? (~b_safe + 32'd1) : b_safe;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign q_s   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = a_neg ? (~r_mag + 32'd1) : r_mag;

  assign q_u = a / b_safe;
  assign r_u = a % b_safe;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    div0   = 1'b0;
    case (op)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MD_DIV: begin
        res_hi = r_s;
        res_lo = q_s;
        div0   = b_zero;
      end
      MD_DIVU: begin
        res_hi = r_u;
        res_lo = q_u;
        div0   = b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit : multi-cycle multiply/divide unit beside the EX-stage ALU.
//   clk    in  pipeline clock, rising edge
//   reset  in  asynchronous active-low reset; clears hi/lo and aborts any op
//   bus    slave modport of md_unit_if (start/op/rs_data/rt_data/rd_sel in,
//          busy/hi/lo/rd_data out)
// The result is computed at the start edge and held in pending registers;
// HI/LO only change when the latency counter runs out, so readers always see
// committed values while an op is in flight.
// -----------------------------------------------------------------------------
module md_unit
  import md_defs::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   bus
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      pend_hi_reg;
  logic [31:0]      pend_lo_reg;
  logic             pend_div0_reg;
  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;

  logic [31:0]      arith_hi;
  logic [31:0]      arith_lo;
  logic             arith_div0;

  md_arith u_arith (
    .op     (bus.op),
    .a      (bus.rs_data),
    .b      (bus.rt_data),
    .res_hi (arith_hi),
    .res_lo (arith_lo),
    .div0   (arith_div0)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      pend_hi_reg   <= 32'd0;
      pend_lo_reg   <= 32'd0;
      pend_div0_reg <= 1'b0;
      hi_reg        <= 32'd0;
      lo_reg        <= 32'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            if (is_mul(bus.op) || is_div(bus.op)) begin
              pend_hi_reg   <= arith_hi;
              pend_lo_reg   <= arith_lo;
              pend_div0_reg <= arith_div0;
              cnt_reg       <= is_mul(bus.op) ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
              state_reg     <= ST_RUN;
            end else if (bus.op == MD_MTHI) begin
              hi_reg <= bus.rs_data;
            end else if (bus.op == MD_MTLO) begin
              lo_reg <= bus.rs_data;
            end
          end
        end
        default: begin
          // start is deliberately ignored here; the hazard unit stalls it.
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= ST_IDLE;
            if (!pend_div0_reg) begin
              hi_reg <= pend_hi_reg;
              lo_reg <= pend_lo_reg;
            end
          end
        end
      endcase
    end
  end

  assign bus.busy    = bus.start | (state_reg == ST_RUN);
  assign bus.hi      = hi_reg;
  assign bus.lo      = lo_reg;
  assign bus.rd_data = bus.rd_sel ? hi_reg : lo_reg;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  import md_defs::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  md_unit_if bus ();

  md_unit #(
    .MULT_LAT (5),
    .DIV_LAT  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t        vecs [8];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge where busy fell.
  task automatic run_op(input string name, input md_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int lat, input bit inject);
    int cyc;
    int guard;
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = a;
    bus.rt_data = b;
    #1;
    check_int({name, " busy_at_start"}, int'(bus.busy), 1);
    cyc   = 1;
    guard = 0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = MD_NONE;
    #1;
    while (bus.busy === 1'b1 && guard < 40) begin
      cyc++;
      guard++;
      check32({name, " hi_hold"}, bus.hi, m_hi);
      check32({name, " lo_hold"}, bus.lo, m_lo);
      if (inject && cyc == 4) begin
        bus.start   = 1'b1;
        bus.op      = MD_MTLO;
        bus.rs_data = 32'h0000AAAA;
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = MD_NONE;
      #1;
    end
    if (guard >= 40) begin
      failures++;
      checks++;
      $display("FAIL %s busy_timeout actual=busy_stuck required=busy_drop", name);
    end
    check_int({name, " busy_cycles"}, cyc, lat + 1);
    check32({name, " hi"}, bus.hi, exp_hi);
    check32({name, " lo"}, bus.lo, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
    $display("op %s a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h busy=%0d cycles",
             name, a, b, bus.hi, bus.lo, cyc);
  endtask

  // Single-cycle op (MTHI/MTLO/NONE) issued in IDLE.
  task automatic single_op(input string name, input md_op_e op, input logic [31:0] val);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = val;
    #1;
    check_int({name, " busy_at_start"}, int'(bus.busy), 1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = MD_NONE;
    #1;
    if (op == MD_MTHI) m_hi = val;
    if (op == MD_MTLO) m_lo = val;
    check_int({name, " busy_after"}, int'(bus.busy), 0);
    check32({name, " hi"}, bus.hi, m_hi);
    check32({name, " lo"}, bus.lo, m_lo);
    $display("op %s val=0x%08h -> hi=0x%08h lo=0x%08h", name, val, bus.hi, bus.lo);
  endtask

  initial begin
    vecs[0] = '{"MULT_neg2x3",   MD_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{"MULTU_same",    MD_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2] = '{"DIV_neg7_2",    MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{"DIVU_15_4",     MD_DIVU,  32'h0000000F, 32'h00000004, 32'h00000003, 32'h00000003, 10};
    vecs[4] = '{"DIV_7_neg2",    MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[5] = '{"MULT_min_min",  MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[6] = '{"MULTU_max_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[7] = '{"DIVU_big",      MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};

    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.op      = MD_NONE;
    bus.rs_data = 32'd0;
    bus.rt_data = 32'd0;
    bus.rd_sel  = 1'b0;
    m_hi        = 32'd0;
    m_lo        = 32'd0;

    // Reset state; busy follows start while in reset.
    @(negedge clk);
    #1;
    check32("reset hi", bus.hi, 32'd0);
    check32("reset lo", bus.lo, 32'd0);
    check_int("reset busy", int'(bus.busy), 0);
    bus.start = 1'b1;
    bus.op    = MD_MULT;
    #1;
    check_int("reset busy_eq_start", int'(bus.busy), 1);
    bus.start = 1'b0;
    bus.op    = MD_NONE;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    $display("reset released hi=0x%08h lo=0x%08h", bus.hi, bus.lo);

    // Table vectors, issued back to back as soon as busy falls.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].lat, 1'b0);
    end

    // Divide by zero leaves HI/LO untouched after a full busy window.
    single_op("MTHI", MD_MTHI, 32'h00001234);
    single_op("MTLO", MD_MTLO, 32'h00005678);
    run_op("DIV_by_zero", MD_DIV, 32'h00000064, 32'h00000000, 32'h00001234, 32'h00005678, 10, 1'b0);
    bus.rd_sel = 1'b0;
    #1;
    check32("rd_sel0 rd_data", bus.rd_data, 32'h00005678);
    bus.rd_sel = 1'b1;
    #1;
    check32("rd_sel1 rd_data", bus.rd_data, 32'h00001234);
    bus.rd_sel = 1'b0;
    $display("rd_sel toggle lo=0x%08h hi=0x%08h", bus.lo, bus.hi);

    // MD_NONE with start has no lasting effect.
    single_op("NONE", MD_NONE, 32'hDEADBEEF);

    // Signed overflow, with a stray MTLO during RUN that must be ignored.
    run_op("DIV_overflow_ign", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, 1'b1);
    checks++;
    if (bus.lo === 32'h0000AAAA) begin
      failures++;
      $display("FAIL ignored_mtlo actual=0x%08h required=not_0x0000AAAA", bus.lo);
    end

    // Back-to-back: MULT right after busy fell, then MFLO, then a new window.
    run_op("MULT_3x4", MD_MULT, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, 5, 1'b0);
    bus.rd_sel = 1'b0;
    #1;
    check32("MFLO rd_data", bus.rd_data, 32'h0000000C);
    $display("MFLO rd_data=0x%08h", bus.rd_data);
    run_op("MULTU_5x6", MD_MULTU, 32'h00000005, 32'h00000006, 32'h00000000, 32'h0000001E, 5, 1'b0);

    // Reset asserted mid-run abandons the op and clears HI/LO immediately.
    m_hi = 32'h00000000;
    m_lo = 32'h0000001E;
    bus.start   = 1'b1;
    bus.op      = MD_MULTU;
    bus.rs_data = 32'hFFFFFFFF;
    bus.rt_data = 32'hFFFFFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = MD_NONE;
    @(negedge clk);
    #1;
    check_int("midrun busy_before_reset", int'(bus.busy), 1);
    reset = 1'b0;
    #1;
    check32("midrun_reset hi", bus.hi, 32'd0);
    check32("midrun_reset lo", bus.lo, 32'd0);
    check_int("midrun_reset busy", int'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) @(negedge clk);
    #1;
    check_int("after_reset busy", int'(bus.busy), 0);
    check32("after_reset hi", bus.hi, 32'd0);
    check32("after_reset lo", bus.lo, 32'd0);
    $display("midrun reset hi=0x%08h lo=0x%08h busy=%0d", bus.hi, bus.lo, bus.busy);
    m_hi = 32'd0;
    m_lo = 32'd0;

    // Unit is usable again after the abandoned op.
    run_op("MULT_after_reset", MD_MULT, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
